// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 6-digit 7-segment driver with per-frame snapshot, slot blanking and leading-zero suppression
module seven_seg_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 16,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] hr_tens,
  input  logic       dp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BL = PW'(BLANK_CYC);
  localparam logic [9:0][6:0] SEG_LUT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [PW-1:0]   r_pre;
  logic [2:0]      r_slot;
  logic [5:0][3:0] r_dig;
  logic            r_dp_en;
  logic            w_last, w_blank, w_lz, w_dp_on;
  logic [3:0]      w_digit;
  logic [6:0]      w_lit, w_seg_on;
  logic [5:0]      w_an_on;
  always_comb begin
    w_last   = r_pre == LAST;
    w_blank  = r_pre < BL;
    w_digit  = r_dig[r_slot];
    w_lit    = w_digit > 4'd9 ? 7'h40 : SEG_LUT[w_digit];
    w_lz     = BLANK_LZ && r_slot == 3'd5 && r_dig[5] == 4'd0;
    w_seg_on = (w_blank || w_lz) ? 7'h00 : w_lit;
    w_dp_on  = !w_blank && r_dp_en && (r_slot == 3'd2 || r_slot == 3'd4);
    w_an_on  = w_blank ? 6'h00 : 6'(1) << r_slot;
  end
  // shadow digits reload only at the very start of a frame, which is always a blanked cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_slot  <= '0;
      r_dig   <= '0;
      r_dp_en <= 1'b0;
      an      <= {6{AN_ACTIVE_LOW}};
      seg     <= {7{SEG_ACTIVE_LOW}};
      dp      <= SEG_ACTIVE_LOW;
    end else begin
      r_pre <= w_last ? '0 : r_pre + 1'b1;
      if (w_last) r_slot <= r_slot == 3'd5 ? 3'd0 : r_slot + 3'd1;
      if (r_pre == '0 && r_slot == 3'd0) begin
        r_dig   <= {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
        r_dp_en <= dp_en;
      end
      an  <= w_an_on ^ {6{AN_ACTIVE_LOW}};
      seg <= w_seg_on ^ {7{SEG_ACTIVE_LOW}};
      dp  <= w_dp_on ^ SEG_ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan order, blanking, snapshot, decode, leading zero and mid-slot reset
module tb_seven_seg_scanner;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic dp_en;
  logic [6:0] seg, seg0;
  logic dp, dp0;
  logic [5:0] an, an0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  seven_seg_scanner #(.SCAN_DIV(4), .BLANK_CYC(1), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens), .dp_en(dp_en), .seg(seg), .dp(dp), .an(an));
  seven_seg_scanner #(.SCAN_DIV(4), .BLANK_CYC(1), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens), .dp_en(dp_en), .seg(seg0), .dp(dp0), .an(an0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic [24:0] v);
    {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, dp_en} = v;
  endtask
  // entry: outputs reflect pre_cnt=0 slot=0; optional input change at (cs, pre_cnt=2)
  task automatic frame(input logic [5:0][6:0] es, input logic [6:0] es0_5, input logic dpen,
                       input int cs, input logic [24:0] nx);
    for (int s = 0; s < 6; s++)
      for (int p = 0; p < 4; p++) begin
        logic [5:0] ea;
        ea = p == 0 ? 6'h3F : 6'h3F & ~(6'd1 << s);
        chk($sformatf("an s%0d p%0d", s, p), 32'(an), 32'(ea));
        chk($sformatf("an0 s%0d p%0d", s, p), 32'(an0), 32'(ea));
        chk($sformatf("seg s%0d p%0d", s, p), 32'(seg), 32'(p == 0 ? 7'h7F : es[s]));
        chk($sformatf("dp s%0d p%0d", s, p), 32'(dp), 32'(!(p != 0 && dpen && (s == 2 || s == 4))));
        if (s == 5 && p != 0) chk($sformatf("seg0 s5 p%0d", p), 32'(seg0), 32'(es0_5));
        if (s == cs && p == 2) set_in(nx);
        tick();
      end
  endtask
  initial begin
    set_in({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1});
    tick();
    tick();
    chk("rst an", 32'(an), 32'h3F);
    chk("rst seg", 32'(seg), 32'h7F);
    chk("rst dp", 32'(dp), 32'h1);
    reset = 1'b0;
    tick();
    frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 7'h79, 1'b1, 3, {4'd1, 4'd2, 4'd3, 4'd7, 4'd5, 4'd6, 1'b1});
    frame({7'h79, 7'h24, 7'h30, 7'h78, 7'h12, 7'h02}, 7'h79, 1'b1, 1, {4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1});
    frame({7'h7F, 7'h10, 7'h40, 7'h12, 7'h40, 7'h40}, 7'h40, 1'b1, 0, {4'd2, 4'hB, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0});
    frame({7'h24, 7'h3F, 7'h12, 7'h10, 7'h12, 7'h10}, 7'h24, 1'b0, -1, '0);
    set_in({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1});
    repeat (13) tick();
    chk("pre-rst an", 32'(an), 32'h37);
    chk("pre-rst seg", 32'(seg), 32'h12);
    reset = 1'b1;
    tick();
    chk("midrst an", 32'(an), 32'h3F);
    chk("midrst seg", 32'(seg), 32'h7F);
    chk("midrst dp", 32'(dp), 32'h1);
    chk("midrst an0", 32'(an0), 32'h3F);
    reset = 1'b0;
    tick();
    frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 7'h79, 1'b1, -1, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
